// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transaction arbiter.
package i2c_pkg;

  localparam int I2C_ADDR_W          = 7;
  localparam int I2C_DATA_W          = 8;
  localparam int DEFAULT_TIMEOUT_CYC = 4096;

  // One transaction in flight: pick a requester, start the engine,
  // wait for completion or timeout, hand the response back.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the farthest offset back to ptr_i so the closest
  // requesting index is the last one written and therefore wins.
  always_comb begin
    int                 j;
    logic [IDX_W-1:0]   j_idx;
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j     = (int'(ptr_i) + k) % NREQ;
      j_idx = IDX_W'(j);
      if (req_i[j_idx]) begin
        idx_o = j_idx;
      end
    end
    if (any_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one byte-level I2C master between NREQ requesters with
// round-robin arbitration, a completion watchdog and error counting.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int ERRCNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_rw,
  input  logic [I2C_ADDR_W*NREQ-1:0] req_addr,
  input  logic [I2C_DATA_W*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [I2C_DATA_W-1:0]      rsp_rdata,
  output logic                       rsp_nack,
  output logic                       rsp_timeout,
  output logic                       m_start,
  output logic                       m_rw,
  output logic [I2C_ADDR_W-1:0]      m_addr,
  output logic [I2C_DATA_W-1:0]      m_wdata,
  output logic                       m_abort,
  input  logic                       m_busy,
  input  logic                       m_done,
  input  logic [I2C_DATA_W-1:0]      m_rdata,
  input  logic                       m_nack,
  output logic [ERRCNT_W-1:0]        err_count
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic                   rw_q, rw_d;
  logic [I2C_ADDR_W-1:0]  addr_q, addr_d;
  logic [I2C_DATA_W-1:0]  wdata_q, wdata_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [I2C_DATA_W-1:0]  rdata_q, rdata_d;
  logic                   nack_q, nack_d;
  logic                   timeout_q, timeout_d;
  logic [ERRCNT_W-1:0]    err_q, err_d;
  logic                   abort_c;
  logic                   err_inc;

  logic [NREQ-1:0]        arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;

  logic [I2C_ADDR_W-1:0]  addr_arr  [NREQ];
  logic [I2C_DATA_W-1:0]  wdata_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*I2C_ADDR_W +: I2C_ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*I2C_DATA_W +: I2C_DATA_W];
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Next-state, latch, watchdog and response capture logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    timer_d   = timer_q;
    rdata_d   = rdata_q;
    nack_d    = nack_q;
    timeout_d = timeout_q;
    abort_c   = 1'b0;
    err_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any && !m_busy) begin
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          rw_d    = req_rw[arb_idx];
          addr_d  = addr_arr[arb_idx];
          wdata_d = wdata_arr[arb_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        // A completion in the final watchdog cycle still counts as a completion.
        if (m_done) begin
          rdata_d   = m_rdata;
          nack_d    = m_nack;
          timeout_d = 1'b0;
          err_inc   = m_nack;
          state_d   = RESP;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          abort_c   = 1'b1;
          rdata_d   = '0;
          nack_d    = 1'b0;
          timeout_d = 1'b1;
          err_inc   = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        gnt_d   = '0;
        ptr_d   = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = (err_inc && (err_q != '1)) ? err_q + 1'b1 : err_q;
  end

  // State and datapath registers; the engine shares this reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      timer_q   <= '0;
      rdata_q   <= '0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      timer_q   <= timer_d;
      rdata_q   <= rdata_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = (state_q == RESP) ? gnt_q : '0;
  assign rsp_rdata   = rdata_q;
  assign rsp_nack    = nack_q;
  assign rsp_timeout = timeout_q;
  assign m_start     = (state_q == ISSUE);
  assign m_abort     = abort_c;
  assign m_rw        = rw_q;
  assign m_addr      = addr_q;
  assign m_wdata     = wdata_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants and
// responses, a negedge monitor pops and compares what the DUT presents.
module tb_i2c_txn_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 16;
  localparam int AW   = 7 * NREQ;
  localparam int DW   = 8 * NREQ;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] req_rw = '0;
  logic [AW-1:0]   req_addr = '0;
  logic [DW-1:0]   req_wdata = '0;
  logic [NREQ-1:0] gnt, done;
  logic [7:0]      rsp_rdata;
  logic            rsp_nack, rsp_timeout;
  logic            m_start, m_rw, m_abort;
  logic [6:0]      m_addr;
  logic [7:0]      m_wdata;
  logic            m_busy = 1'b0;
  logic            m_done = 1'b0;
  logic [7:0]      m_rdata = '0;
  logic            m_nack = 1'b0;
  logic [7:0]      err_count;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO), .ERRCNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout), .m_start(m_start),
    .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_abort(m_abort),
    .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata), .m_nack(m_nack),
    .err_count(err_count)
  );

  typedef struct { int idx; logic rw; logic [6:0] addr; logic [7:0] wdata; int cyc; } gexp_t;
  typedef struct { int idx; logic [7:0] rdata; logic nack; logic to; int cyc; } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  // stimulus controls (written by the initial block only)
  logic [NREQ-1:0] hold_mask = '0;
  bit   rand_mode = 0, busy_force = 0, use_fix = 0, fix_rsp = 0, end_chk = 0;
  logic fix_rw = 0, fix_nack = 0;
  logic [6:0] fix_addr = '0;
  logic [7:0] fix_wdata = '0, fix_rdata = '0;
  int   fix_d = 0;
  int   wait_fail = 0;

  // driver state
  int cyc = 0;

  // model / monitor state (written by the monitor only)
  int   n_cmp = 0, n_bad = 0, done_total = 0, wait_fail_seen = 0;
  bit   model_busy = 0, eng_active = 0, abort_pending = 0, err_pending = 0;
  int   model_idx = 0, ptr_m = 0, eng_deadline = 0, abort_cyc = 0;
  int   err_m = 0;
  logic [7:0] eng_rdata = '0;
  logic eng_nack = 0;
  logic [NREQ-1:0] done_last = '0;
  gexp_t mg;
  rexp_t mr;
  bit   m_done_now;
  int   mw, md;
  logic [7:0] mrd;
  logic mnk;
  logic [NREQ-1:0] moh;

  function automatic int rr_pick(logic [NREQ-1:0] r, int p);
    int j;
    logic [NREQ-1:0] t;
    for (int k = 0; k < NREQ; k++) begin
      j = (p + k) % NREQ;
      t = r >> j;
      if (t[0]) return j;
    end
    return -1;
  endfunction

  function automatic logic bit_of(logic [NREQ-1:0] v, int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Driver: requesters and I2C engine, inputs change 1 time unit after posedge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rst) begin
      req = '0; m_done = 1'b0; m_busy = 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bit_of(req, i) && bit_of(done_last, i)) begin
          req = req & ~(NREQ'(1) << i);
        end else if (!bit_of(req, i)) begin
          if (bit_of(hold_mask, i) || (rand_mode && $urandom_range(0, 7) == 0)) begin
            req = req | (NREQ'(1) << i);
            req_rw    = (req_rw & ~(NREQ'(1) << i)) |
                        (NREQ'(use_fix ? fix_rw : $urandom_range(0, 1) == 1) << i);
            req_addr  = (req_addr & ~(AW'(7'h7F) << (7 * i))) |
                        (AW'(use_fix ? fix_addr : 7'($urandom)) << (7 * i));
            req_wdata = (req_wdata & ~(DW'(8'hFF) << (8 * i))) |
                        (DW'(use_fix ? fix_wdata : 8'($urandom)) << (8 * i));
          end
        end else if (rand_mode && model_busy && model_idx == i && $urandom_range(0, 3) == 0) begin
          // fields change after the latch; the DUT must ignore this
          req_addr  = req_addr ^ (AW'(7'($urandom)) << (7 * i));
          req_wdata = req_wdata ^ (DW'(8'($urandom)) << (8 * i));
          req_rw    = req_rw ^ (NREQ'(1) << i);
        end
      end
      if (eng_active) m_done = (cyc == eng_deadline);
      else            m_done = rand_mode && ($urandom_range(0, 15) == 0);
      m_rdata = (eng_active && m_done) ? eng_rdata : 8'($urandom);
      m_nack  = (eng_active && m_done) ? eng_nack  : ($urandom_range(0, 1) == 1);
      m_busy  = busy_force || (rand_mode && !eng_active && $urandom_range(0, 3) == 0);
    end
  end

  // Monitor + reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    m_done_now = 0;
    if (rst) begin
      n_cmp++;
      if ({gnt, done, m_start, m_abort, err_count, rsp_rdata, rsp_nack, rsp_timeout,
           m_rw, m_addr, m_wdata} != '0) begin
        n_bad++;
        $display("FAIL reset_outputs: gnt=%b done=%b m_start=%b m_abort=%b err_count=%0d rsp_rdata=%h m_addr=%h required all zero",
                 gnt, done, m_start, m_abort, err_count, rsp_rdata, m_addr);
      end
      gq.delete(); rq.delete();
      model_busy = 0; eng_active = 0; abort_pending = 0; err_pending = 0;
      ptr_m = 0; err_m = 0; done_last = '0;
    end else begin
      if (wait_fail != wait_fail_seen) begin
        n_cmp++; n_bad++;
        $display("FAIL wait_budget: expired waits=%0d required 0", wait_fail);
        wait_fail_seen = wait_fail;
      end
      if ($countones(gnt) > 1) begin
        n_cmp++; n_bad++;
        $display("FAIL gnt_onehot: gnt=%b required at most one bit", gnt);
      end
      if (err_pending) begin
        n_cmp++;
        if (int'(err_count) != err_m) begin
          n_bad++;
          $display("FAIL err_count: got %0d required %0d", err_count, err_m);
        end
        err_pending = 0;
      end
      // issue check
      if (m_start) begin
        n_cmp++;
        if (gq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_start: m_start=1 at cycle %0d, required no start", cyc);
        end else begin
          mg  = gq.pop_front();
          moh = NREQ'(1) << mg.idx;
          if (gnt != moh || m_rw != mg.rw || m_addr != mg.addr || m_wdata != mg.wdata ||
              cyc != mg.cyc + 1 || m_abort) begin
            n_bad++;
            $display("FAIL issue: gnt=%b rw=%b addr=%h wdata=%h cyc=%0d abort=%b required gnt=%b rw=%b addr=%h wdata=%h cyc=%0d abort=0",
                     gnt, m_rw, m_addr, m_wdata, cyc, m_abort, moh, mg.rw, mg.addr, mg.wdata, mg.cyc + 1);
          end
          md  = (fix_d != 0) ? fix_d : int'($urandom_range(1, 20));
          mrd = fix_rsp ? fix_rdata : 8'($urandom);
          mnk = fix_rsp ? fix_nack : ($urandom_range(0, 3) == 0);
          eng_active = 1; eng_deadline = cyc + md; eng_rdata = mrd; eng_nack = mnk;
          if (md <= TO) begin
            rq.push_back('{idx: mg.idx, rdata: mrd, nack: mnk, to: 1'b0, cyc: cyc + md + 1});
          end else begin
            rq.push_back('{idx: mg.idx, rdata: 8'h00, nack: 1'b0, to: 1'b1, cyc: cyc + TO + 1});
            abort_pending = 1; abort_cyc = cyc + TO;
          end
        end
      end else if (gq.size() != 0 && cyc > gq[0].cyc + 1) begin
        n_cmp++; n_bad++;
        $display("FAIL missing_start: no m_start by cycle %0d, required at %0d", cyc, gq[0].cyc + 1);
        void'(gq.pop_front());
        model_busy = 0;
      end
      // engine completion already driven this cycle
      if (eng_active && !abort_pending && cyc == eng_deadline) eng_active = 0;
      // watchdog abort
      if (m_abort || (abort_pending && cyc == abort_cyc)) begin
        n_cmp++;
        if (!(m_abort && abort_pending && cyc == abort_cyc && !m_start)) begin
          n_bad++;
          $display("FAIL abort: m_abort=%b m_start=%b cyc=%0d required m_abort=%b at cyc %0d with m_start=0",
                   m_abort, m_start, cyc, abort_pending, abort_cyc);
        end
        abort_pending = 0; eng_active = 0;
      end
      // response check
      if (done != '0) begin
        done_total++;
        done_last = done;
        m_done_now = 1;
        n_cmp++;
        if (rq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: done=%b at cycle %0d, required none", done, cyc);
        end else begin
          mr  = rq.pop_front();
          moh = NREQ'(1) << mr.idx;
          if (done != moh || cyc != mr.cyc || rsp_timeout != mr.to || rsp_rdata != mr.rdata ||
              (!mr.to && rsp_nack != mr.nack)) begin
            n_bad++;
            $display("FAIL response: done=%b cyc=%0d rdata=%h nack=%b timeout=%b required done=%b cyc=%0d rdata=%h nack=%b timeout=%b",
                     done, cyc, rsp_rdata, rsp_nack, rsp_timeout, moh, mr.cyc, mr.rdata, mr.nack, mr.to);
          end else begin
            $display("txn req=%0d rdata=%h nack=%b timeout=%b cycle=%0d", mr.idx, rsp_rdata, rsp_nack, rsp_timeout, cyc);
          end
          if ((mr.nack && !mr.to) || mr.to) err_m = (err_m < 255) ? err_m + 1 : 255;
          err_pending = 1;
          ptr_m = (mr.idx + 1) % NREQ;
        end
        model_busy = 0;
      end else begin
        done_last = '0;
        if (rq.size() != 0 && cyc > rq[0].cyc) begin
          n_cmp++; n_bad++;
          $display("FAIL missing_done: no done by cycle %0d, required at %0d", cyc, rq[0].cyc);
          void'(rq.pop_front());
          model_busy = 0;
        end
      end
      // arbitration as seen by the next rising edge
      if (!model_busy && !m_done_now && req != '0 && !m_busy) begin
        mw = rr_pick(req, ptr_m);
        gq.push_back('{idx: mw, rw: bit_of(req_rw, mw), addr: 7'(req_addr >> (7 * mw)),
                       wdata: 8'(req_wdata >> (8 * mw)), cyc: cyc});
        model_busy = 1; model_idx = mw;
      end
      if (end_chk) begin
        n_cmp++;
        if (gq.size() != 0 || rq.size() != 0) begin
          n_bad++;
          $display("FAIL drain: pending grants=%0d responses=%0d required 0", gq.size(), rq.size());
        end
      end
    end
  end

  task automatic wait_dones(input int n, input int budget);
    int target;
    target = done_total + n;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #2;
      if (done_total >= target) return;
    end
    wait_fail++;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #2;
      if (req == '0 && !model_busy && rq.size() == 0 && gq.size() == 0) return;
    end
    wait_fail++;
  endtask

  task automatic one_txn(input int r, input logic rw, input logic [6:0] a, input logic [7:0] wd,
                         input int d, input logic [7:0] rd, input logic nk);
    use_fix = 1; fix_rw = rw; fix_addr = a; fix_wdata = wd;
    fix_d = d; fix_rsp = 1; fix_rdata = rd; fix_nack = nk;
    hold_mask = NREQ'(1) << r;
    wait_dones(1, 200);
    hold_mask = '0;
    drain(200);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    // single read, requester 1
    one_txn(1, 1'b1, 7'h48, 8'h00, 12, 8'hA5, 1'b0);
    // all four requesters held, 10-cycle engine
    use_fix = 0; fix_rsp = 0; fix_d = 10;
    hold_mask = '1;
    wait_dones(5, 400);
    hold_mask = '0;
    drain(400);
    // write with NACK, requester 2
    one_txn(2, 1'b0, 7'h20, 8'h3C, 8, 8'h00, 1'b1);
    // engine never completes -> watchdog abort
    one_txn(0, 1'b1, 7'h11, 8'h00, 100, 8'h00, 1'b0);
    // completion in the last watchdog cycle wins over the abort
    one_txn(3, 1'b1, 7'h33, 8'h00, TO, 8'h5A, 1'b0);
    // engine busy holds off arbitration
    busy_force = 1;
    use_fix = 1; fix_d = 6; fix_rsp = 1; fix_rdata = 8'hC3; fix_nack = 0;
    hold_mask = 4'b0001;
    repeat (10) @(negedge clk);
    busy_force = 0;
    wait_dones(1, 100);
    hold_mask = '0;
    drain(200);
    // randomized traffic
    use_fix = 0; fix_rsp = 0; fix_d = 0; rand_mode = 1;
    repeat (600) @(posedge clk);
    rand_mode = 0;
    drain(800);
    // reset while waiting on the engine
    use_fix = 1; fix_d = 100; fix_rsp = 1;
    hold_mask = 4'b0010;
    for (int k = 0; k < 100 && !eng_active; k++) @(negedge clk);
    if (!eng_active) wait_fail++;
    repeat (3) @(posedge clk);
    hold_mask = '0;
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (10) @(negedge clk);
    one_txn(2, 1'b1, 7'h2A, 8'h00, 5, 8'h77, 1'b0);
    end_chk = 1;
    @(negedge clk);
    end_chk = 0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
